checker_mem_loader: RTL and testbench
=====================================

// Module: checker_mem_loader
// PURPOSE
// Wishbone initiator that fills the checker's byte-addressed program memory from a byte stream.
// Packs incoming bytes little-endian into 32-bit words and issues single Wishbone write cycles with the matching wb_sel.
// Optionally reads each word back and compares it to what was written.
// Sits between the host byte source (UART/FIFO) and the checker memory Wishbone slave, sharing sys_clk.
// PARAMETERS
// ADR_W    15   byte-address width of the target memory (8 RAMs x 4096 B)
// TIMEOUT  255  cycles to wait for wb_ack_i before aborting a cycle
// PORTS
// sys_clk    in   1      system clock
// sys_rst    in   1      synchronous reset, active-low
// start      in   1      1-cycle pulse; latched only in IDLE
// verify     in   1      sampled with start; 1 = read back every written word
// base_adr   in   ADR_W  first byte address, sampled with start; any alignment
// len        in   16     byte count, sampled with start; 0 = no transfer
// s_dat      in   8      stream byte
// s_valid    in   1      s_dat valid
// s_ready    out  1      byte accepted when s_valid & s_ready
// busy       out  1      high from the cycle after start until done
// done       out  1      1-cycle pulse when the job ends (normally or by abort)
// err        out  1      sticky verify mismatch; cleared by the next start
// timeout    out  1      sticky ack timeout; cleared by the next start
// err_adr    out  ADR_W  word-aligned byte address of the first mismatch or timeout
// wb_adr_o   out  32     {zeros, word address, 2'b00}
// wb_dat_o   out  32     write data, lane k = byte at address word+k
// wb_dat_i   in   32     read data
// wb_sel_o   out  4      byte lanes; bit k = lane k
// wb_cyc_o   out  1      bus cycle
// wb_stb_o   out  1      strobe
// wb_we_o    out  1      1 = write
// wb_ack_i   in   1      slave acknowledge
// BEHAVIOUR
// Reset (sys_rst=0): state IDLE. All outputs are 0, including wb_*, s_ready, busy, done, err, timeout and err_adr. Internal address, count, lane and timers are 0.
// States: IDLE, FILL, WRITE, READ, DONE.
// IDLE: on start, latch base_adr, len and verify; clear err, timeout and err_adr; clear the pack register; lane = base_adr[1:0].
//   Next state is FILL, or DONE if len = 0. start is ignored in every other state.
// FILL: s_ready = 1. Each accepted byte goes into pack lane `lane`, sets sel[lane], and decrements the remaining count.
//   Go to WRITE when lane = 3 or the remaining count reaches 0; otherwise lane increments.
// WRITE: assert cyc, stb and we with adr, dat and sel held stable until wb_ack_i. s_ready = 0.
//   On ack: drop cyc and stb in the same clock edge.
//   Next state on ack: READ if verify = 1; otherwise FILL (count > 0) or DONE (count = 0).
// READ: cyc = 1, stb = 1, we = 0, same address. On ack, compare wb_dat_i to the pack register on the sel lanes only.
//   On mismatch: set err; load err_adr only if err and timeout were both 0.
//   Then go to FILL or DONE as in WRITE.
// Leaving WRITE/READ toward FILL: word address +1, which wraps modulo 2^ADR_W (0x7FFC -> 0x0000). lane = 0; sel and pack are cleared.
// Timeout: a per-cycle counter resets when stb rises. If it reaches TIMEOUT with no ack:
//   drop cyc and stb, set timeout, load err_adr if it is not yet set, go to DONE. Remaining stream bytes are not consumed.
// DONE: done = 1 for one cycle, busy = 0, then IDLE.
// Ack handling: an ack seen while stb = 0 is ignored. Back-to-back cycles always leave at least 1 idle bus cycle between them.
// Per byte, the stream is throttled only through s_ready. An s_valid without s_ready has no effect.
// Throughput: with a 1-cycle-ack slave and verify = 0, an aligned word takes 4 fill + 2 bus cycles.
// Reset mid-operation: abort immediately, with no bus cycle completion required; all outputs are 0 on the next edge.
// TESTING
// Aligned job: base=0x0010, len=8, bytes 11..18, verify=0.
//   -> writes adr 0x10 sel=F dat=0x14131211, then adr 0x14 dat=0x18171615; 1 done pulse.
// Unaligned job: base=0x0003, len=3, bytes AA BB CC.
//   -> writes adr 0x0 sel=8 dat[31:24]=AA, then adr 0x4 sel=3 dat[15:0]=0xCCBB.
// Wrap: base=0x7FFE, len=4.
//   -> writes 0x7FFC sel=C, then 0x0000 sel=3.
// Verify with a slave that corrupts word 0x20 (returns 0xDEADBEEF).
//   -> err=1, err_adr=0x20, the job still completes, done pulses.
// Timeout: slave never acks at the 2nd word (base 0).
//   -> after 255 cycles cyc=0, timeout=1, err_adr=0x4, done pulses, s_ready stays 0.
// Other cases: len=0 gives done 2 cycles after start with no wb_cyc_o. start while busy is ignored.
//   sys_rst=0 during WRITE gives all outputs 0 on the next edge.

Source files
------------

// File: rtl/checker_mem_loader.sv
// Wishbone initiator that packs a byte stream little-endian into 32-bit words and
// writes them into the checker program memory, with optional read-back compare.
module checker_mem_loader #(
  parameter int unsigned ADR_W   = 15,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             verify,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [15:0]      len,
  input  logic [7:0]       s_dat,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             timeout,
  output logic [ADR_W-1:0] err_adr,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i
);

  localparam int unsigned WA_W  = ADR_W - 2;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_READ, S_DONE} state_t;

  state_t           r_state, w_state_n;
  logic [WA_W-1:0]  r_wadr, w_wadr_n;
  logic [15:0]      r_cnt, w_cnt_n;
  logic [1:0]       r_lane, w_lane_n;
  logic [31:0]      r_pack, w_pack_n;
  logic [3:0]       r_sel, w_sel_n;
  logic             r_verify, w_verify_n;
  logic [TMR_W-1:0] r_tmr, w_tmr_n;
  logic             r_cyc, w_cyc_n;
  logic             r_stb, w_stb_n;
  logic             r_we, w_we_n;
  logic             r_sready, w_sready_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             r_err, w_err_n;
  logic             r_tout, w_tout_n;
  logic [ADR_W-1:0] r_err_adr, w_err_adr_n;
  logic [31:0]      w_mask;
  logic             w_mism;

  assign w_mask = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
  assign w_mism = ((wb_dat_i ^ r_pack) & w_mask) != 32'd0;

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state   <= S_IDLE;
      r_wadr    <= '0;
      r_cnt     <= '0;
      r_lane    <= '0;
      r_pack    <= '0;
      r_sel     <= '0;
      r_verify  <= 1'b0;
      r_tmr     <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_sready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tout    <= 1'b0;
      r_err_adr <= '0;
    end else begin
      r_state   <= w_state_n;
      r_wadr    <= w_wadr_n;
      r_cnt     <= w_cnt_n;
      r_lane    <= w_lane_n;
      r_pack    <= w_pack_n;
      r_sel     <= w_sel_n;
      r_verify  <= w_verify_n;
      r_tmr     <= w_tmr_n;
      r_cyc     <= w_cyc_n;
      r_stb     <= w_stb_n;
      r_we      <= w_we_n;
      r_sready  <= w_sready_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
      r_tout    <= w_tout_n;
      r_err_adr <= w_err_adr_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_n   = r_state;
    w_wadr_n    = r_wadr;
    w_cnt_n     = r_cnt;
    w_lane_n    = r_lane;
    w_pack_n    = r_pack;
    w_sel_n     = r_sel;
    w_verify_n  = r_verify;
    w_tmr_n     = r_tmr;
    w_cyc_n     = r_cyc;
    w_stb_n     = r_stb;
    w_we_n      = r_we;
    w_sready_n  = r_sready;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_err_n     = r_err;
    w_tout_n    = r_tout;
    w_err_adr_n = r_err_adr;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_wadr_n    = base_adr[ADR_W-1:2];
          w_cnt_n     = len;
          w_verify_n  = verify;
          w_lane_n    = base_adr[1:0];
          w_pack_n    = '0;
          w_sel_n     = '0;
          w_err_n     = 1'b0;
          w_tout_n    = 1'b0;
          w_err_adr_n = '0;
          if (len == 16'd0) begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
          end else begin
            w_state_n  = S_FILL;
            w_sready_n = 1'b1;
            w_busy_n   = 1'b1;
          end
        end
      end

      S_FILL: begin
        if (s_valid && r_sready) begin
          w_pack_n[{r_lane, 3'b000} +: 8] = s_dat;
          w_sel_n[r_lane]                 = 1'b1;
          w_cnt_n                         = r_cnt - 16'd1;
          if (r_lane == 2'd3 || r_cnt == 16'd1) begin
            w_state_n  = S_WRITE;
            w_sready_n = 1'b0;
            w_cyc_n    = 1'b1;
            w_stb_n    = 1'b1;
            w_we_n     = 1'b1;
            w_tmr_n    = '0;
          end else begin
            w_lane_n = r_lane + 2'd1;
          end
        end
      end

      S_WRITE, S_READ: begin
        if (!r_stb) begin
          // Read strobe starts one cycle after the write ack to leave an idle bus cycle
          w_cyc_n = 1'b1;
          w_stb_n = 1'b1;
          w_tmr_n = '0;
        end else if (wb_ack_i) begin
          w_cyc_n = 1'b0;
          w_stb_n = 1'b0;
          w_we_n  = 1'b0;
          if (r_state == S_READ && w_mism) begin
            w_err_n = 1'b1;
            if (!r_err && !r_tout) w_err_adr_n = {r_wadr, 2'b00};
          end
          if (r_state == S_WRITE && r_verify) begin
            w_state_n = S_READ;
          end else if (r_cnt != 16'd0) begin
            w_state_n  = S_FILL;
            w_wadr_n   = r_wadr + WA_W'(1);
            w_lane_n   = '0;
            w_sel_n    = '0;
            w_pack_n   = '0;
            w_sready_n = 1'b1;
          end else begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
          end
        end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
          w_cyc_n   = 1'b0;
          w_stb_n   = 1'b0;
          w_we_n    = 1'b0;
          w_tout_n  = 1'b1;
          if (!r_err && !r_tout) w_err_adr_n = {r_wadr, 2'b00};
          w_state_n = S_DONE;
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
        end else begin
          w_tmr_n = r_tmr + TMR_W'(1);
        end
      end

      S_DONE: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  assign s_ready  = r_sready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign timeout  = r_tout;
  assign err_adr  = r_err_adr;
  assign wb_adr_o = {{(32 - ADR_W){1'b0}}, r_wadr, 2'b00};
  assign wb_dat_o = r_pack;
  assign wb_sel_o = r_sel;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_stb;
  assign wb_we_o  = r_we;

endmodule

// File: tb/tb_checker_mem_loader.sv
// Directed bench for checker_mem_loader: table of loader jobs against a Wishbone
// memory model that can corrupt one word or withhold ack, plus reset corner cases.
module tb_checker_mem_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        start = 1'b0;
  logic        verify = 1'b0;
  logic [14:0] base_adr = '0;
  logic [15:0] len = '0;
  logic [7:0]  s_dat = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, busy, done, err, timeout;
  logic [14:0] err_adr;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic        wb_ack_i = 1'b0;

  checker_mem_loader #(.ADR_W(15), .TIMEOUT(255)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .verify(verify),
    .base_adr(base_adr), .len(len), .s_dat(s_dat), .s_valid(s_valid),
    .s_ready(s_ready), .busy(busy), .done(done), .err(err), .timeout(timeout),
    .err_adr(err_adr), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_ack_i(wb_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  // Slave model controls
  logic        noack_en = 1'b0;
  logic [31:0] noack_adr = '0;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_adr = '0;

  logic [31:0] mem [0:8191];
  logic [31:0] lg_adr [0:63];
  logic [31:0] lg_dat [0:63];
  logic [3:0]  lg_sel [0:63];
  logic        lg_we  [0:63];
  int          lg_cyc [0:63];
  int          lg_n = 0;

  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  // One-cycle-ack memory slave; logs every completed cycle
  always @(posedge sys_clk) begin
    if (wb_ack_i) begin
      wb_ack_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o && lg_n < 64) begin
        lg_adr[lg_n] <= wb_adr_o;
        lg_dat[lg_n] <= wb_dat_o;
        lg_sel[lg_n] <= wb_sel_o;
        lg_we[lg_n]  <= wb_we_o;
        lg_cyc[lg_n] <= cyc_cnt;
        lg_n         <= lg_n + 1;
        if (wb_we_o)
          for (int k = 0; k < 4; k++)
            if (wb_sel_o[k]) mem[wb_adr_o[14:2]][8*k +: 8] <= wb_dat_o[8*k +: 8];
      end
    end else if (wb_cyc_o && wb_stb_o && !(noack_en && wb_adr_o == noack_adr)) begin
      wb_ack_i <= 1'b1;
      if (!wb_we_o)
        wb_dat_i <= (corrupt_en && wb_adr_o == corrupt_adr) ? 32'hDEADBEEF : mem[wb_adr_o[14:2]];
    end
  end

  typedef struct {
    logic [14:0]  base;
    logic [15:0]  len;
    logic         verify;
    logic [127:0] bytes;
    logic         noack_en;
    logic [31:0]  noack_adr;
    logic         corrupt_en;
    logic [31:0]  corrupt_adr;
    logic         mid_start;
    int           nwr;
    int           nrd;
    logic [31:0]  adr0;
    logic [3:0]   sel0;
    logic [31:0]  dat0;
    logic [31:0]  adr1;
    logic [3:0]   sel1;
    logic [31:0]  dat1;
    logic         err;
    logic         tout;
    logic [14:0]  err_adr;
    int           consumed;
    int           max_stb;
    int           ack_gap;
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [127:0] all_outs();
    return {37'd0, wb_cyc_o, wb_stb_o, wb_we_o, s_ready, busy, done, err, timeout,
            err_adr, wb_adr_o, wb_dat_o, wb_sel_o};
  endfunction

  task automatic run_job(input int j);
    vec_t v;
    int idx, cons, dones, run, maxrun, gapv, post, s0, nw, nr, wi0, wi1;
    logic hs, acc_prev;
    logic [31:0] a, d;
    logic [3:0] s;
    v = vecs[j];
    idx = 0; cons = 0; dones = 0; run = 0; maxrun = 0; gapv = 0; post = -1;
    acc_prev = 1'b0;
    noack_en = v.noack_en; noack_adr = v.noack_adr;
    corrupt_en = v.corrupt_en; corrupt_adr = v.corrupt_adr;
    s0 = lg_n;
    @(negedge sys_clk);
    start = 1'b1; base_adr = v.base; len = v.len; verify = v.verify;
    s_valid = (v.len != 16'd0); s_dat = v.bytes[7:0];
    hs = s_valid & s_ready;
    for (int c = 0; c < 2000; c++) begin
      @(negedge sys_clk);
      start = v.mid_start && c == 2;
      if (start) begin base_adr = 15'h0300; len = 16'd1; end
      if (hs) begin idx++; cons++; end
      s_valid = idx < int'(v.len);
      s_dat = v.bytes[8*idx +: 8];
      hs = s_valid & s_ready;
      if (done) dones++;
      run = wb_stb_o ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (acc_prev && wb_cyc_o) gapv++;
      acc_prev = wb_stb_o & wb_ack_i;
      if (post >= 0) post++;
      else if (done) post = 0;
      if (post == 3) break;
    end
    s_valid = 1'b0;
    chk($sformatf("j%0d_done_seen", j), 128'(post == 3), 128'd1);
    nw = 0; nr = 0; wi0 = -1; wi1 = -1;
    for (int k = s0; k < lg_n; k++) begin
      if (lg_we[k]) begin
        if (nw == 0) wi0 = k;
        else if (nw == 1) wi1 = k;
        nw++;
      end else nr++;
    end
    chk($sformatf("j%0d_nwrites", j), 128'(nw), 128'(v.nwr));
    chk($sformatf("j%0d_nreads", j), 128'(nr), 128'(v.nrd));
    if (v.nwr >= 1) begin
      a = (wi0 >= 0) ? lg_adr[wi0] : '1;
      s = (wi0 >= 0) ? lg_sel[wi0] : '1;
      d = (wi0 >= 0) ? lg_dat[wi0] : '1;
      chk($sformatf("j%0d_w0_adr", j), 128'(a), 128'(v.adr0));
      chk($sformatf("j%0d_w0_sel", j), 128'(s), 128'(v.sel0));
      chk($sformatf("j%0d_w0_dat", j), 128'(d & lmask(v.sel0)), 128'(v.dat0));
    end
    if (v.nwr >= 2) begin
      a = (wi1 >= 0) ? lg_adr[wi1] : '1;
      s = (wi1 >= 0) ? lg_sel[wi1] : '1;
      d = (wi1 >= 0) ? lg_dat[wi1] : '1;
      chk($sformatf("j%0d_w1_adr", j), 128'(a), 128'(v.adr1));
      chk($sformatf("j%0d_w1_sel", j), 128'(s), 128'(v.sel1));
      chk($sformatf("j%0d_w1_dat", j), 128'(d & lmask(v.sel1)), 128'(v.dat1));
      if (v.ack_gap != 0 && wi0 >= 0 && wi1 >= 0)
        chk($sformatf("j%0d_word_period", j), 128'(lg_cyc[wi1] - lg_cyc[wi0]), 128'(v.ack_gap));
    end
    chk($sformatf("j%0d_err", j), 128'(err), 128'(v.err));
    chk($sformatf("j%0d_timeout", j), 128'(timeout), 128'(v.tout));
    chk($sformatf("j%0d_err_adr", j), 128'(err_adr), 128'(v.err_adr));
    chk($sformatf("j%0d_bytes_taken", j), 128'(cons), 128'(v.consumed));
    chk($sformatf("j%0d_done_pulses", j), 128'(dones), 128'd1);
    chk($sformatf("j%0d_max_stb_run", j), 128'(maxrun), 128'(v.max_stb));
    chk($sformatf("j%0d_idle_gap_viol", j), 128'(gapv), 128'd0);
    chk($sformatf("j%0d_idle_outs", j), 128'({s_ready, busy, wb_cyc_o}), 128'd0);
  endtask

  initial begin
    // base len vfy bytes noack corrupt mid | nwr nrd | w0 | w1 | err tout err_adr | taken max_stb gap
    vecs[0] = '{15'h0010, 16'd8, 1'b0, 128'h1817161514131211, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,
                2, 0, 32'h10, 4'hF, 32'h14131211, 32'h14, 4'hF, 32'h18171615, 1'b0, 1'b0, 15'h0, 8, 2, 6};
    vecs[1] = '{15'h0003, 16'd3, 1'b0, 128'hCCBBAA, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                2, 0, 32'h0, 4'h8, 32'hAA000000, 32'h4, 4'h3, 32'h0000CCBB, 1'b0, 1'b0, 15'h0, 3, 2, 0};
    vecs[2] = '{15'h7FFE, 16'd4, 1'b0, 128'h24232221, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                2, 0, 32'h7FFC, 4'hC, 32'h22210000, 32'h0, 4'h3, 32'h00002423, 1'b0, 1'b0, 15'h0, 4, 2, 0};
    vecs[3] = '{15'h001C, 16'd8, 1'b1, 128'h3837363534333231, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0,
                2, 2, 32'h1C, 4'hF, 32'h34333231, 32'h20, 4'hF, 32'h38373635, 1'b1, 1'b0, 15'h20, 8, 2, 0};
    vecs[4] = '{15'h0000, 16'd12, 1'b0, 128'h4C4B4A494847464544434241, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0,
                1, 0, 32'h0, 4'hF, 32'h44434241, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 15'h4, 8, 255, 0};
    vecs[5] = '{15'h0040, 16'd5, 1'b1, 128'h5554535251, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                2, 2, 32'h40, 4'hF, 32'h54535251, 32'h44, 4'h1, 32'h00000055, 1'b0, 1'b0, 15'h0, 5, 2, 0};
    vecs[6] = '{15'h0100, 16'd0, 1'b0, 128'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 0, 0, 0};
    vecs[7] = '{15'h0202, 16'd1, 1'b1, 128'h77, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                1, 1, 32'h200, 4'h4, 32'h00770000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 1, 2, 0};

    repeat (4) @(negedge sys_clk);
    chk("reset_outputs", all_outs(), 128'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("idle_outputs", all_outs(), 128'd0);

    // Reset while a write cycle is stalled
    begin
      int w;
      noack_en = 1'b1; noack_adr = 32'h44;
      start = 1'b1; base_adr = 15'h0044; len = 16'd4; verify = 1'b0;
      s_valid = 1'b1; s_dat = 8'h5A;
      @(negedge sys_clk);
      start = 1'b0;
      w = 0;
      while (!wb_cyc_o && w < 30) begin @(negedge sys_clk); w++; end
      chk("rst_write_reached", 128'(wb_cyc_o & wb_we_o), 128'd1);
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("rst_mid_write_outs", all_outs(), 128'd0);
      sys_rst = 1'b1; s_valid = 1'b0; noack_en = 1'b0;
      repeat (2) @(negedge sys_clk);
      chk("rst_recover_outs", all_outs(), 128'd0);
    end

    for (int j = 0; j < 8; j++) run_job(j);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
